ifetch_ctrl: RTL

- Fetch controller on the other end of the PC register's interface.
- Produces the next-PC value that the PC register loads every cycle: hold, +4, or redirect.
- Fetches the instruction at the current PC from instruction memory over a req/gnt/rvalid interface.
- Presents the fetched instruction to decode with a valid/ready handshake; services branch redirects, squashing stale fetches.

---
 rtl/ifetch_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: drives the PC register's next value, fetches
// one instruction at a time over req/gnt/rvalid and hands it to decode.
module ifetch_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              drop_q, drop_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

  logic [ADDR_W-1:0] target_aligned;
  logic [ADDR_W-1:0] pc_inc;

  assign target_aligned = {branch_target[ADDR_W-1:2], 2'b00};
  assign pc_inc         = pc + ADDR_W'(PC_STEP);

  always_comb begin
    if (branch_valid)                     next_pc = target_aligned;
    else if (inst_valid_q && inst_ready)  next_pc = pc_inc;
    else                                  next_pc = pc;
  end

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = fetch_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    unique case (state_q)
      IDLE: begin
        state_d      = REQ;
        fetch_addr_d = next_pc;
      end
      REQ: begin
        // A redirect cannot retarget a pending request; mark its response stale.
        if (branch_valid) drop_d = 1'b1;
        if (imem_gnt)     state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || branch_valid) begin
            drop_d       = 1'b0;
            state_d      = REQ;
            fetch_addr_d = next_pc;
          end else begin
            inst_d       = imem_rdata;
            inst_pc_d    = fetch_addr_q;
            inst_valid_d = 1'b1;
            state_d      = HOLD;
          end
        end else if (branch_valid) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (branch_valid) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
          fetch_addr_d = target_aligned;
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
          fetch_addr_d = pc_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

endmodule
